// File: rtl/gfx_rom_server.sv
// Two-entry (demand + prefetch) word cache that serves byte reads from the
// tile/sprite fetcher out of a 16-bit external ROM, with optional next-word prefetch.
module gfx_rom_server #(
  parameter int PREFETCH = 1,
  parameter int MEM_AW   = 18
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              gfx_read,
  input  logic [18:0]       gfx_addr,
  output logic [7:0]        gfx_data,
  output logic              gfx_valid,
  output logic              gfx_busy,
  input  logic              gfx_flush,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, FETCH, GAP, PREF} state_t;

  state_t            state;
  logic [MEM_AW-1:0] d_tag, p_tag;
  logic [15:0]       d_data, p_data;
  logic              d_vld, p_vld;
  logic              pend_vld;
  logic [18:0]       pend_addr;
  logic              fetch_byte;     // byte lane of the demand fetch in flight
  logic              xfer_flushed;   // a flush hit the transfer in flight
  logic              gap_from_pref;  // GAP after PREF always returns to IDLE

  logic [18:0]       req_addr;
  logic [MEM_AW-1:0] req_word, next_tag;
  logic              d_hit, p_hit, p_holds_next, pend_in_flight;

  function automatic logic [7:0] pick(input logic [15:0] w, input logic b);
    return b ? w[15:8] : w[7:0];
  endfunction

  // NOTE: every signal gets an unconditional assignment here, so no latch can be inferred.
  always_comb begin
    req_addr       = gfx_read ? gfx_addr : pend_addr;
    req_word       = MEM_AW'(req_addr[18:1]);
    next_tag       = d_tag + MEM_AW'(1);
    d_hit          = d_vld && !gfx_flush && (d_tag == req_word);
    p_hit          = p_vld && !gfx_flush && (p_tag == req_word);
    p_holds_next   = p_vld && (p_tag == next_tag);
    pend_in_flight = pend_vld && !gfx_read && (MEM_AW'(pend_addr[18:1]) == mem_addr);
  end

  assign gfx_busy = (state == FETCH) || pend_vld;

  // NOTE: all state uses non-blocking assignments; later assignments in this block
  // deliberately override earlier ones (flush beats any load in the same cycle).
  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      state         <= IDLE;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      gfx_data      <= 8'h00;
      gfx_valid     <= 1'b0;
      d_tag         <= '0;
      p_tag         <= '0;
      d_data        <= '0;
      p_data        <= '0;
      d_vld         <= 1'b0;
      p_vld         <= 1'b0;
      pend_vld      <= 1'b0;
      pend_addr     <= '0;
      fetch_byte    <= 1'b0;
      xfer_flushed  <= 1'b0;
      gap_from_pref <= 1'b0;
    end else begin
      gfx_valid <= 1'b0;

      if (gfx_read && state != IDLE) begin
        pend_vld  <= 1'b1;
        pend_addr <= gfx_addr;
      end

      case (state)
        IDLE: begin
          if (gfx_read || pend_vld) begin
            pend_vld <= 1'b0;
            if (d_hit) begin
              gfx_valid <= 1'b1;
              gfx_data  <= pick(d_data, req_addr[0]);
            end else if (p_hit) begin
              gfx_valid <= 1'b1;
              gfx_data  <= pick(p_data, req_addr[0]);
              d_tag     <= p_tag;
              d_data    <= p_data;
              d_vld     <= 1'b1;
              p_vld     <= 1'b0;
              if (PREFETCH == 1) begin
                state         <= GAP;
                gap_from_pref <= 1'b0;
              end
            end else begin
              state        <= FETCH;
              mem_req      <= 1'b1;
              mem_addr     <= req_word;
              fetch_byte   <= req_addr[0];
              xfer_flushed <= 1'b0;
            end
          end
        end

        FETCH: begin
          if (mem_ack) begin
            mem_req       <= 1'b0;
            d_tag         <= mem_addr;
            d_data        <= mem_rdata;
            d_vld         <= !xfer_flushed;
            gfx_valid     <= 1'b1;
            gfx_data      <= pick(mem_rdata, fetch_byte);
            state         <= GAP;
            gap_from_pref <= 1'b0;
          end
        end

        GAP: begin
          if (!gap_from_pref && PREFETCH == 1 && !p_holds_next) begin
            state        <= PREF;
            mem_req      <= 1'b1;
            mem_addr     <= next_tag;
            xfer_flushed <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        PREF: begin
          if (mem_ack) begin
            mem_req       <= 1'b0;
            p_tag         <= mem_addr;
            p_data        <= mem_rdata;
            p_vld         <= !xfer_flushed;
            state         <= GAP;
            gap_from_pref <= 1'b1;
            // A waiting read for the word being prefetched is answered straight from the bus.
            if (pend_in_flight) begin
              gfx_valid <= 1'b1;
              gfx_data  <= pick(mem_rdata, pend_addr[0]);
              pend_vld  <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase

      if (gfx_flush) begin
        d_vld        <= 1'b0;
        p_vld        <= 1'b0;
        xfer_flushed <= 1'b1;
      end
    end
  end

endmodule

// File: doc/gfx_rom_server.md
GFX_ROM_SERVER -- requirements
Module: gfx_rom_server

Interface
REQ-001 The block SHALL have parameter PREFETCH, default 1, meaning that a next-word prefetch is enabled when the value is 1.
REQ-002 The block SHALL have parameter MEM_AW, default 18, meaning the width of the external word address.
REQ-003 clk_sys  input  1  system clock; all logic rises on posedge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on posedge clk_sys.
REQ-005 gfx_read  input  1  one-cycle read strobe from the tile/sprite fetcher.
REQ-006 gfx_addr  input  19  byte address, sampled when gfx_read=1.
REQ-007 gfx_data  output  8  returned byte; holds its value until the next gfx_valid.
REQ-008 gfx_valid  output  1  one-cycle pulse; gfx_data is valid in the same cycle.
REQ-009 gfx_busy  output  1  high while a demand miss is outstanding or a request is pending.
REQ-010 gfx_flush  input  1  invalidates both cache entries (asserted during ROM download).
REQ-011 mem_req  output  1  external 16-bit memory read request.
REQ-012 mem_addr  output  MEM_AW  word address (gfx_addr[18:1]).
REQ-013 mem_ack  input  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
REQ-014 mem_rdata  input  16  word data; the byte with gfx_addr[0]=0 is [7:0], and the byte with gfx_addr[0]=1 is [15:8].

Function
REQ-015 The block SHALL hold two word entries: D (demand) and P (prefetch), each with an 18-bit tag, a 16-bit data field and a valid bit.
REQ-016 The FSM SHALL have the states IDLE, FETCH, GAP and PREF.
REQ-017 Hit: when gfx_read=1 in IDLE and gfx_addr[18:1] matches a valid D or P tag, the block SHALL assert gfx_valid with the selected byte on the next cycle (latency 1).
REQ-018 A hit in P SHALL copy P into D, invalidate P and, if PREFETCH=1, go to GAP and then PREF for tag+1.
REQ-019 Miss: IDLE SHALL go to FETCH, with mem_req=1 and mem_addr=gfx_addr[18:1] from the next cycle.
REQ-020 mem_req and mem_addr SHALL be held stable until mem_ack=1 is sampled; they SHALL never be withdrawn early, except by reset.
REQ-021 On mem_ack in FETCH, the block SHALL load D (tag, data, valid=1) and SHALL pulse gfx_valid with the selected byte on the next cycle (miss latency = 1 cycle + memory latency + 1 cycle).
REQ-022 mem_req SHALL be 0 in the cycle after any mem_ack (state GAP); back-to-back requests SHALL be separated by at least one idle cycle.
REQ-023 After GAP, the FSM SHALL go to PREF if PREFETCH=1 and P does not already hold D.tag+1; otherwise it SHALL go to IDLE.
REQ-024 PREF SHALL issue mem_addr=D.tag+1, which wraps from 18'h3FFFF to 0; on mem_ack it SHALL load P and go to GAP then IDLE.
REQ-025 Pending register: a gfx_read while the state is not IDLE SHALL latch its address; a later gfx_read before service SHALL overwrite it (last wins).
REQ-026 A pending request SHALL be serviced in the first IDLE cycle, exactly as in REQ-017 to REQ-019.
REQ-027 A pending request whose word is currently in flight in PREF SHALL be answered one cycle after that mem_ack, with no second memory read.
REQ-028 gfx_busy SHALL be 1 in FETCH and whenever the pending register is valid; PREF alone SHALL NOT set gfx_busy.
REQ-029 gfx_valid SHALL pulse at most once per serviced request; a dropped (overwritten) request SHALL produce no pulse.
REQ-030 gfx_flush SHALL clear the D and P valid bits in the same cycle.
REQ-031 A transaction in flight during gfx_flush SHALL complete, but its data SHALL NOT be cached; a demand fetch SHALL still return its byte.
REQ-032 mem_ack while mem_req=0 SHALL be ignored.
REQ-033 gfx_read and mem_ack in the same cycle SHALL both take effect: the ack completes and the read is latched as pending.

Reset
REQ-034 While reset=0 at a clock edge, the block SHALL set state=IDLE and mem_req=0, mem_addr=0, gfx_data=8'h00, gfx_valid=0 and gfx_busy=0.
REQ-035 While reset=0 at a clock edge, the block SHALL clear both valid bits and the pending register.
REQ-036 A reset during FETCH or PREF SHALL drop mem_req on that edge, and a late mem_ack after release SHALL be ignored (REQ-032).

Verification
REQ-037 Cold miss: read 19'h00010 with the memory returning 16'hBEEF after 3 cycles -> gfx_data=8'hEF.
  - gfx_valid SHALL pulse 1 cycle after the ack.
  - Then a PREF request to word 18'h00009 SHALL follow, after one gap cycle.
REQ-038 Hit: after REQ-037, read 19'h00011 -> gfx_data=8'hBE one cycle later, with no mem_req.
REQ-039 Prefetch hit: read 19'h00012 after P has loaded 16'h1234 -> gfx_data=8'h34 at latency 1, and a new PREF to word 18'h0000A.
REQ-040 Pending overwrite: during a 5-cycle FETCH, reads of 19'h00100 then 19'h00200 -> exactly two gfx_valid pulses (the original read and 19'h00200), and none for 19'h00100.
REQ-041 Wrap: miss at 19'h7FFFE -> the PREF mem_addr is 18'h00000.
REQ-042 Flush and reset: gfx_flush, then re-read of a cached address -> a new mem_req. A reset=0 mid-FETCH -> mem_req=0 next edge, and a stray mem_ack produces no gfx_valid.
